rab_lookup_arbiter: RTL and testbench
=====================================

# rab_lookup_arbiter

Arbitrates the single shared RAB TLB lookup between two slave-side requesters (port 1 = write address channel, port 2 = read address channel). It grants one port at a time, drives the `select` and per-port address-valid inputs of the RAB response FSM, and locks the grant until that port reports the transaction sent. Grants alternate round-robin. A watchdog recovers the arbiter if the granted port never completes.

## Interface
Parameters:
- LOOKUP_LAT, default 2: TLB lookup latency in cycles, from `lookup_req_o` to a valid hit/miss result. Legal range 1..15.
- TIMEOUT_W, default 10: width of the WAIT watchdog counter. Timeout fires after 2^TIMEOUT_W-1 cycles.

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- port1_req_i  in  1  port 1 has an address pending (level)
- port2_req_i  in  1  port 2 has an address pending (level)
- port1_sent_i  in  1  port 1 transaction forwarded or dropped (pulse)
- port2_sent_i  in  1  port 2 transaction forwarded or dropped (pulse)
- lookup_req_o  out  1  one-cycle pulse that starts a TLB lookup for the granted port
- select_o  out  1  granted port: 1 = port 1, 0 = port 2
- port1_addr_valid_o  out  1  one-cycle pulse: port 1 lookup result valid
- port2_addr_valid_o  out  1  one-cycle pulse: port 2 lookup result valid
- busy_o  out  1  high whenever state != IDLE
- timeout_o  out  1  one-cycle pulse: watchdog expired

## Operation
- States: IDLE, LOOKUP, RESULT, WAIT.
- IDLE: if any request is present, latch the grant and go to LOOKUP.
  - Only one request: grant that port.
  - Both requests: grant the port given by round-robin pointer `rr_q`.
- LOOKUP: lasts exactly LOOKUP_LAT cycles, tracked by a down-counter loaded with LOOKUP_LAT-1. `lookup_req_o` is high in the first LOOKUP cycle only. Then go to RESULT.
- RESULT: one cycle. Pulse `portN_addr_valid_o` for the granted port only. Go to WAIT.
- WAIT: hold until the granted port's `sent` input is high, then go to IDLE.
  - The `sent` input of the non-granted port is ignored in every state.
- Completion happens either on the granted port's `sent` in RESULT or WAIT, or on timeout. On completion, `rr_q` is set to the port that was not granted.
- Watchdog:
  - Counter cleared on entry to WAIT; increments each WAIT cycle.
  - At all-ones: pulse `timeout_o`, go to IDLE, update `rr_q` as for completion.
  - The counter saturates and never wraps into a false completion.
- `select_o` is loaded when leaving IDLE and held constant through LOOKUP, RESULT and WAIT. It keeps its value in IDLE.
- A request that drops while its port is granted has no effect; the grant is held until `sent` or timeout.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values: `lookup_req_o`, `port1_addr_valid_o`, `port2_addr_valid_o`, `busy_o` and `timeout_o` = 0; `select_o` = 0. State resets to IDLE, `rr_q` to port 1, counters to 0.
- Request sampled in IDLE at cycle t:
  - `lookup_req_o` and `busy_o` are high at t+1, and `select_o` is valid at t+1.
  - `addr_valid` pulses at t+LOOKUP_LAT+1.
  - WAIT starts at t+LOOKUP_LAT+2.
- `sent` sampled at cycle s: IDLE at s+1, `busy_o` low at s+1. Earliest next `lookup_req_o` is s+2.
- `sent` in the RESULT cycle counts as completion: go to IDLE next cycle, skip WAIT.
- Simultaneous `port1_sent_i` and `port2_sent_i`: only the granted port's `sent` is honored.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. Any in-flight lookup result is discarded; no `addr_valid` pulse is issued.

## Structure
- Package `rab_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, LOOKUP, RESULT, WAIT} rab_arb_state_t`;
  - constants `RAB_PORT1 = 1'b1` and `RAB_PORT2 = 1'b0`.
- Sub-module `rab_arb_watchdog` (parameter TIMEOUT_W): clear input, enable input, saturating counter, `expired` output. It is instantiated once.
- Everything else is flat in `rab_lookup_arbiter`.

## Test plan
- Single request, LOOKUP_LAT=2: `port1_req_i` at t=0 → `lookup_req_o` at 1; `port1_addr_valid_o` at 3; `port1_sent_i` at 6 → `busy_o` low at 7; `select_o`=1 throughout.
- Both requests held high from reset: grants alternate port1, port2, port1, ... Each `addr_valid` pulse matches `select_o`; the other port's `addr_valid` stays 0.
- Wrong-port `sent`: port 1 granted, pulse `port2_sent_i` in WAIT → arbiter stays in WAIT; then `port1_sent_i` → IDLE.
- Watchdog, TIMEOUT_W=3: no `sent` after grant → `timeout_o` pulses once after 7 WAIT cycles, then IDLE; the next grant goes to the other port if both request.
- Reset mid-LOOKUP, and `sent` in the RESULT cycle:
  - deassert Rst_RBI during LOOKUP → all outputs 0 immediately, and no `addr_valid` pulse afterwards;
  - `sent` in RESULT → IDLE next cycle, with no WAIT cycle.

Source files
------------

// File: rtl/rab_arb_pkg.sv
// Shared types and constants for the RAB lookup arbiter: the FSM state encoding
// and the encoding of the select line.
package rab_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESULT, WAIT} rab_arb_state_t;

    localparam logic RAB_PORT1 = 1'b1;
    localparam logic RAB_PORT2 = 1'b0;

    // Wide enough for the largest legal lookup latency (15).
    localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/rab_arb_watchdog.sv
// Saturating watchdog counter for the arbiter's WAIT state.
// The expired output is high while the count sits at all-ones.
module rab_arb_watchdog #(
    parameter int unsigned TIMEOUT_W = 10
) (
    input  logic Clk_CI,
    input  logic Rst_RBI,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Holding at all-ones means the count can never wrap back to a quiet value.
    assign expired = &cnt_q;

endmodule

// File: rtl/rab_lookup_arbiter.sv
// Round-robin arbiter sharing one RAB TLB lookup between the write (port 1) and
// read (port 2) address channels, with a watchdog on the post-result wait.
module rab_lookup_arbiter
    import rab_arb_pkg::*;
#(
    parameter int unsigned LOOKUP_LAT = 2,
    parameter int unsigned TIMEOUT_W  = 10
) (
    input  logic Clk_CI,
    input  logic Rst_RBI,
    input  logic port1_req_i,
    input  logic port2_req_i,
    input  logic port1_sent_i,
    input  logic port2_sent_i,
    output logic lookup_req_o,
    output logic select_o,
    output logic port1_addr_valid_o,
    output logic port2_addr_valid_o,
    output logic busy_o,
    output logic timeout_o
);

    rab_arb_state_t       state_q, state_d;
    logic                 select_q, select_d;
    logic                 rr_q, rr_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic                 wd_clear, wd_enable, wd_expired;
    logic                 timeout_fire;
    logic                 granted_sent;

    logic lookup_req_q, port1_av_q, port2_av_q, busy_q, timeout_q;

    rab_arb_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) i_watchdog (
        .Clk_CI  (Clk_CI),
        .Rst_RBI (Rst_RBI),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // The other port's sent is never looked at.
    assign granted_sent = (select_q == RAB_PORT1) ? port1_sent_i : port2_sent_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        rr_d         = rr_q;
        lat_cnt_d    = lat_cnt_q;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;
        timeout_fire = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (port1_req_i || port2_req_i) begin
                    if (port1_req_i && port2_req_i) begin
                        select_d = rr_q;
                    end else begin
                        select_d = port1_req_i ? RAB_PORT1 : RAB_PORT2;
                    end
                    lat_cnt_d = LAT_CNT_W'(LOOKUP_LAT - 1);
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESULT;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESULT: begin
                if (granted_sent) begin
                    state_d = IDLE;
                    rr_d    = ~select_q;
                end else begin
                    state_d  = WAIT;
                    wd_clear = 1'b1;
                end
            end
            WAIT: begin
                wd_enable = 1'b1;
                if (granted_sent) begin
                    state_d = IDLE;
                    rr_d    = ~select_q;
                end else if (wd_expired) begin
                    state_d      = IDLE;
                    rr_d         = ~select_q;
                    timeout_fire = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q      <= IDLE;
            select_q     <= RAB_PORT2;
            rr_q         <= RAB_PORT1;
            lat_cnt_q    <= '0;
            lookup_req_q <= 1'b0;
            port1_av_q   <= 1'b0;
            port2_av_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            rr_q         <= rr_d;
            lat_cnt_q    <= lat_cnt_d;
            lookup_req_q <= (state_q == IDLE) && (state_d == LOOKUP);
            port1_av_q   <= (state_d == RESULT) && (select_d == RAB_PORT1);
            port2_av_q   <= (state_d == RESULT) && (select_d == RAB_PORT2);
            busy_q       <= (state_d != IDLE);
            timeout_q    <= timeout_fire;
        end
    end

    assign lookup_req_o       = lookup_req_q;
    assign select_o           = select_q;
    assign port1_addr_valid_o = port1_av_q;
    assign port2_addr_valid_o = port2_av_q;
    assign busy_o             = busy_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_rab_lookup_arbiter.sv
// Directed self-checking bench for rab_lookup_arbiter with LOOKUP_LAT=2 and a
// 3-bit watchdog; cycle numbers in comments count from the cycle a request is first set.
module tb_rab_lookup_arbiter;

    logic Clk_CI = 1'b0;
    logic Rst_RBI = 1'b0;
    logic port1_req_i = 1'b0, port2_req_i = 1'b0;
    logic port1_sent_i = 1'b0, port2_sent_i = 1'b0;
    logic lookup_req_o, select_o, port1_addr_valid_o, port2_addr_valid_o, busy_o, timeout_o;

    int total = 0;
    int bad   = 0;

    rab_lookup_arbiter #(
        .LOOKUP_LAT (2),
        .TIMEOUT_W  (3)
    ) dut (
        .Clk_CI             (Clk_CI),
        .Rst_RBI            (Rst_RBI),
        .port1_req_i        (port1_req_i),
        .port2_req_i        (port2_req_i),
        .port1_sent_i       (port1_sent_i),
        .port2_sent_i       (port2_sent_i),
        .lookup_req_o       (lookup_req_o),
        .select_o           (select_o),
        .port1_addr_valid_o (port1_addr_valid_o),
        .port2_addr_valid_o (port2_addr_valid_o),
        .busy_o             (busy_o),
        .timeout_o          (timeout_o)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit past the rising edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk_CI);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {26'd0, lookup_req_o, select_o, port1_addr_valid_o,
                               port2_addr_valid_o, busy_o, timeout_o}, 32'd0);
    endtask

    task automatic do_reset();
        Rst_RBI = 1'b0;
        cyc(2);
        Rst_RBI = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        #3;
        check_all_zero("reset");
        cyc(2);
        Rst_RBI = 1'b1;
        check_all_zero("post_reset");

        // Single request on port 1, sent at cycle 6
        port1_req_i = 1'b1;
        cyc();                                   // c1
        check("t1_lookup_c1", lookup_req_o, 1);
        check("t1_busy_c1", busy_o, 1);
        check("t1_sel_c1", select_o, 1);
        port1_req_i = 1'b0;
        cyc();                                   // c2
        check("t1_lookup_c2", lookup_req_o, 0);
        check("t1_av1_c2", port1_addr_valid_o, 0);
        cyc();                                   // c3
        check("t1_av1_c3", port1_addr_valid_o, 1);
        check("t1_av2_c3", port2_addr_valid_o, 0);
        check("t1_sel_c3", select_o, 1);
        cyc();                                   // c4 (WAIT)
        check("t1_av1_c4", port1_addr_valid_o, 0);
        check("t1_busy_c4", busy_o, 1);
        cyc(2);                                  // c6
        check("t1_busy_c6", busy_o, 1);
        port1_sent_i = 1'b1;
        cyc();                                   // c7
        port1_sent_i = 1'b0;
        check("t1_busy_c7", busy_o, 0);
        check("t1_sel_c7", select_o, 1);

        // Wrong-port sent in WAIT is ignored
        port1_req_i = 1'b1;
        cyc();                                   // c1
        port1_req_i = 1'b0;
        check("t3_sel", select_o, 1);
        cyc(3);                                  // c4 (WAIT)
        port2_sent_i = 1'b1;
        cyc();                                   // c5
        port2_sent_i = 1'b0;
        check("t3_busy_after_wrong_sent", busy_o, 1);
        cyc();                                   // c6
        check("t3_busy_c6", busy_o, 1);
        port1_sent_i = 1'b1;
        cyc();                                   // c7
        port1_sent_i = 1'b0;
        check("t3_busy_after_sent", busy_o, 0);

        // Both requesting from reset: grants alternate 1,0,1,0; both sents pulsed together
        do_reset();
        port1_req_i = 1'b1;
        port2_req_i = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic exp_sel;
            exp_sel = (g % 2 == 0);
            cyc();                               // c1
            check($sformatf("rr%0d_lookup", g), lookup_req_o, 1);
            check($sformatf("rr%0d_sel", g), select_o, exp_sel);
            cyc(2);                              // c3
            check($sformatf("rr%0d_av1", g), port1_addr_valid_o, exp_sel);
            check($sformatf("rr%0d_av2", g), port2_addr_valid_o, !exp_sel);
            cyc();                               // c4 (WAIT)
            port1_sent_i = 1'b1;
            port2_sent_i = 1'b1;
            if (g == 3) begin
                port1_req_i = 1'b0;
                port2_req_i = 1'b0;
            end
            cyc();                               // c5 (IDLE)
            port1_sent_i = 1'b0;
            port2_sent_i = 1'b0;
            check($sformatf("rr%0d_busy_done", g), busy_o, 0);
        end

        // Watchdog: WAIT starts at c4, count reaches 7 at c11, timeout_o at c12
        port1_req_i = 1'b1;
        port2_req_i = 1'b1;
        cyc();                                   // c1
        check("wd_sel_first", select_o, 1);
        cyc(10);                                 // c11
        check("wd_timeout_c11", timeout_o, 0);
        check("wd_busy_c11", busy_o, 1);
        cyc();                                   // c12
        check("wd_timeout_c12", timeout_o, 1);
        check("wd_busy_c12", busy_o, 0);
        cyc();                                   // c13
        check("wd_timeout_c13", timeout_o, 0);
        check("wd_next_lookup", lookup_req_o, 1);
        check("wd_next_sel", select_o, 0);
        cyc(2);                                  // c15
        check("wd_next_av2", port2_addr_valid_o, 1);
        cyc();                                   // c16 (WAIT)
        port2_sent_i = 1'b1;
        port1_req_i  = 1'b0;
        port2_req_i  = 1'b0;
        cyc();                                   // c17
        port2_sent_i = 1'b0;
        check("wd_next_done", busy_o, 0);

        // Reset mid-LOOKUP discards the lookup
        port1_req_i = 1'b1;
        cyc();                                   // c1
        port1_req_i = 1'b0;
        check("rst_lookup_started", busy_o, 1);
        #2;
        Rst_RBI = 1'b0;
        #1;
        check_all_zero("rst_mid_lookup");
        cyc();
        Rst_RBI = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("rst_no_av_%0d", k),
                  {30'd0, port1_addr_valid_o, port2_addr_valid_o}, 32'd0);
        end

        // Sent in RESULT completes without any WAIT cycle
        port2_req_i = 1'b1;
        cyc();                                   // c1
        port2_req_i = 1'b0;
        check("res_sel", select_o, 0);
        cyc(2);                                  // c3 (RESULT)
        check("res_av2", port2_addr_valid_o, 1);
        port2_sent_i = 1'b1;
        cyc();                                   // c4
        port2_sent_i = 1'b0;
        check("res_busy_c4", busy_o, 0);
        cyc();                                   // c5
        check("res_busy_c5", busy_o, 0);
        check("res_lookup_c5", lookup_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
